// File: rtl/uart_word_serializer_if.sv
// Bundle of the word-side and UART-side signals of uart_word_serializer.
// The slave modport is the serializer's view; master is the environment's view.
interface uart_word_serializer_if #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 8
) ();
    localparam int DATA_W  = 8 * WORD_BYTES;
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

    logic               WriteEnable;
    logic [DATA_W-1:0]  Data_In;
    logic               MSB_First;
    logic               Clear_Overflow;
    logic               Tx_Busy;
    logic               Tx_Start;
    logic [7:0]         Tx_Data;
    logic               Full;
    logic               Empty;
    logic [LEVEL_W-1:0] Level;
    logic               Overflow;
    logic               Busy;
    logic               Word_Done;

    modport slave (
        input  WriteEnable, Data_In, MSB_First, Clear_Overflow, Tx_Busy,
        output Tx_Start, Tx_Data, Full, Empty, Level, Overflow, Busy, Word_Done
    );

    modport master (
        output WriteEnable, Data_In, MSB_First, Clear_Overflow, Tx_Busy,
        input  Tx_Start, Tx_Data, Full, Empty, Level, Overflow, Busy, Word_Done
    );
endinterface

// File: rtl/uart_word_serializer.sv
// Word-to-byte serializer: words are queued in a small FIFO together with
// their byte-order bit and then handed to a UART one byte at a time over a
// Tx_Start/Tx_Busy handshake.
module uart_word_serializer #(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    uart_word_serializer_if.slave   bus
);
    localparam int DATA_W  = 8 * WORD_BYTES;
    localparam int ENTRY_W = DATA_W + 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    // Reverse the byte order of a word so the FSM can always emit the low
    // byte first and shift right, whatever order the word asked for.
    function automatic logic [DATA_W-1:0] f_reverse_bytes(input logic [DATA_W-1:0] i_word);
        logic [DATA_W-1:0] v_word;
        v_word = '0;
        for (int b = 0; b < WORD_BYTES; b++) begin
            v_word[8*b +: 8] = i_word[8*(WORD_BYTES-1-b) +: 8];
        end
        return v_word;
    endfunction

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [LEVEL_W-1:0] r_level;
    logic               r_full;
    logic               r_empty;
    logic               r_overflow;

    // Transmit FSM
    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic               r_busy;
    logic               r_word_done;

    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_head;
    logic [LEVEL_W-1:0] w_level_next;
    logic               w_is_last;

    // The head is only taken while idle, so a push at Full is legal exactly
    // on the cycle the FSM pops.
    assign w_pop     = (r_state == ST_IDLE) && !r_empty;
    assign w_push    = bus.WriteEnable && (!r_full || w_pop);
    assign w_drop    = bus.WriteEnable && r_full && !w_pop;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_is_last = (r_cnt == CNT_W'(WORD_BYTES - 1));

    // Next occupancy from this cycle's push/pop combination.
    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LEVEL_W'(1);
            2'b01:   w_level_next = r_level - LEVEL_W'(1);
            default: w_level_next = r_level;
        endcase
    end

    // Word storage; contents need no reset because the pointers gate them.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.MSB_First, bus.Data_In};
        end
    end

    // FIFO pointers, registered status flags and the sticky overflow flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LEVEL_W'(FIFO_DEPTH));
            r_empty <= (w_level_next == LEVEL_W'(0));
            // A new drop wins over a simultaneous clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.Clear_Overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Byte-sequencing FSM with the UART handshake.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_empty) begin
                        r_shift <= w_head[DATA_W] ? f_reverse_bytes(w_head[DATA_W-1:0])
                                                  : w_head[DATA_W-1:0];
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!bus.Tx_Busy) begin
                        r_tx_data  <= r_shift[7:0];
                        r_shift    <= r_shift >> 4'd8;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (bus.Tx_Busy) begin
                        r_tx_start <= 1'b0;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!bus.Tx_Busy) begin
                        if (w_is_last) begin
                            r_word_done <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + CNT_W'(1);
                            r_state <= ST_SEND;
                        end
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Tx_Start  = r_tx_start;
    assign bus.Tx_Data   = r_tx_data;
    assign bus.Full      = r_full;
    assign bus.Empty     = r_empty;
    assign bus.Level     = r_level;
    assign bus.Overflow  = r_overflow;
    assign bus.Busy      = r_busy;
    assign bus.Word_Done = r_word_done;
endmodule

// File: tb/tb_uart_word_serializer.sv
// Directed bench for uart_word_serializer: a 4-byte/8-deep instance and a
// 2-byte/4-deep instance, each with a small UART responder.
module tb_uart_word_serializer;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    uart_word_serializer_if #(.WORD_BYTES(4), .FIFO_DEPTH(8)) ifa ();
    uart_word_serializer_if #(.WORD_BYTES(2), .FIFO_DEPTH(4)) ifb ();

    uart_word_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(8)) dut_a (.Clock(clk), .Reset(rst_a), .bus(ifa));
    uart_word_serializer #(.WORD_BYTES(2), .FIFO_DEPTH(4)) dut_b (.Clock(clk), .Reset(rst_b), .bus(ifb));

    int n_vec = 0;
    int n_mis = 0;

    // UART responder A: raises busy one cycle after Tx_Start, holds it 10 cycles.
    logic       auto_a = 1'b1, force_a = 1'b0, mb_a = 1'b0, prev_a = 1'b0;
    int         cnt_a = 0, wd_a = 0, lvl_max_a = 0;
    logic [7:0] log_a[$];
    assign ifa.Tx_Busy = auto_a ? mb_a : force_a;

    always @(negedge clk) begin
        if (cnt_a != 0) begin
            cnt_a = cnt_a - 1;
            mb_a  = (cnt_a != 0);
        end else if (ifa.Tx_Start && !mb_a) begin
            mb_a  = 1'b1;
            cnt_a = 10;
        end
        if (ifa.Tx_Start && !prev_a) log_a.push_back(ifa.Tx_Data);
        prev_a = ifa.Tx_Start;
        if (ifa.Word_Done) wd_a = wd_a + 1;
        if (int'(ifa.Level) > lvl_max_a) lvl_max_a = int'(ifa.Level);
    end

    // UART responder B, same behaviour.
    logic       auto_b = 1'b1, force_b = 1'b0, mb_b = 1'b0, prev_b = 1'b0;
    int         cnt_b = 0, wd_b = 0;
    logic [7:0] log_b[$];
    assign ifb.Tx_Busy = auto_b ? mb_b : force_b;

    always @(negedge clk) begin
        if (cnt_b != 0) begin
            cnt_b = cnt_b - 1;
            mb_b  = (cnt_b != 0);
        end else if (ifb.Tx_Start && !mb_b) begin
            mb_b  = 1'b1;
            cnt_b = 10;
        end
        if (ifb.Tx_Start && !prev_b) log_b.push_back(ifb.Tx_Data);
        prev_b = ifb.Tx_Start;
        if (ifb.Word_Done) wd_b = wd_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_a_drained(input string tag, input int maxc);
        int n;
        n = 0;
        while (!(ifa.Busy == 1'b0 && ifa.Empty == 1'b1) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, (n < maxc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_b_drained(input string tag, input int maxc);
        int n;
        n = 0;
        while (!(ifb.Busy == 1'b0 && ifb.Empty == 1'b1) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(tag, (n < maxc) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        ifa.WriteEnable = 1'b0; ifa.Data_In = 32'h0; ifa.MSB_First = 1'b0; ifa.Clear_Overflow = 1'b0;
        ifb.WriteEnable = 1'b0; ifb.Data_In = 16'h0; ifb.MSB_First = 1'b0; ifb.Clear_Overflow = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_tx_start", {31'd0, ifa.Tx_Start}, 32'd0);
        chk("rst_tx_data",  {24'd0, ifa.Tx_Data}, 32'd0);
        chk("rst_empty",    {31'd0, ifa.Empty}, 32'd1);
        chk("rst_full",     {31'd0, ifa.Full}, 32'd0);
        chk("rst_level",    {28'd0, ifa.Level}, 32'd0);
        chk("rst_overflow", {31'd0, ifa.Overflow}, 32'd0);
        chk("rst_busy",     {31'd0, ifa.Busy}, 32'd0);
        chk("rst_word_done",{31'd0, ifa.Word_Done}, 32'd0);
        chk("rst_b_empty",  {31'd0, ifb.Empty}, 32'd1);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: one MSB-first word, latency and byte order
        ifa.WriteEnable = 1'b1; ifa.Data_In = 32'hA1B2C3D4; ifa.MSB_First = 1'b1;
        @(negedge clk);
        ifa.WriteEnable = 1'b0; ifa.MSB_First = 1'b0;
        chk("t1_empty_after_push", {31'd0, ifa.Empty}, 32'd0);
        chk("t1_level_after_push", {28'd0, ifa.Level}, 32'd1);
        @(negedge clk);
        chk("t1_level_after_pop", {28'd0, ifa.Level}, 32'd0);
        chk("t1_busy_after_pop",  {31'd0, ifa.Busy}, 32'd1);
        chk("t1_start_not_yet",   {31'd0, ifa.Tx_Start}, 32'd0);
        @(negedge clk);
        chk("t1_start_k2", {31'd0, ifa.Tx_Start}, 32'd1);
        chk("t1_data_k2",  {24'd0, ifa.Tx_Data}, 32'hA1);
        wait_a_drained("t1_drain_timeout", 1000);
        chk("t1_nbytes", log_a.size(), 32'd4);
        if (log_a.size() == 4) begin
            chk("t1_b0", {24'd0, log_a[0]}, 32'hA1);
            chk("t1_b1", {24'd0, log_a[1]}, 32'hB2);
            chk("t1_b2", {24'd0, log_a[2]}, 32'hC3);
            chk("t1_b3", {24'd0, log_a[3]}, 32'hD4);
        end
        chk("t1_word_done", wd_a, 32'd1);
        chk("t1_busy_end", {31'd0, ifa.Busy}, 32'd0);

        // Test 2: back-to-back words with different byte orders
        log_a.delete(); wd_a = 0; lvl_max_a = 0;
        ifa.WriteEnable = 1'b1; ifa.Data_In = 32'hA1B2C3D4; ifa.MSB_First = 1'b0;
        @(negedge clk);
        ifa.Data_In = 32'h11223344; ifa.MSB_First = 1'b1;
        @(negedge clk);
        ifa.WriteEnable = 1'b0; ifa.MSB_First = 1'b0;
        wait_a_drained("t2_drain_timeout", 2000);
        chk("t2_nbytes", log_a.size(), 32'd8);
        if (log_a.size() == 8) begin
            chk("t2_bytes_0_3", {log_a[0], log_a[1], log_a[2], log_a[3]}, 32'hD4C3B2A1);
            chk("t2_bytes_4_7", {log_a[4], log_a[5], log_a[6], log_a[7]}, 32'h11223344);
        end
        chk("t2_word_done", wd_a, 32'd2);
        chk("t2_level_peak", lvl_max_a, 32'd1);

        // Test 3: UART stalled, fill to Full and overflow
        auto_a = 1'b0; force_a = 1'b1;
        log_a.delete(); wd_a = 0;
        for (int i = 1; i <= 10; i++) begin
            ifa.WriteEnable = 1'b1; ifa.Data_In = 32'h10000000 + i; ifa.MSB_First = 1'b0;
            @(negedge clk);
        end
        ifa.WriteEnable = 1'b0;
        chk("t3_full",     {31'd0, ifa.Full}, 32'd1);
        chk("t3_level",    {28'd0, ifa.Level}, 32'd8);
        chk("t3_overflow", {31'd0, ifa.Overflow}, 32'd1);
        chk("t3_busy",     {31'd0, ifa.Busy}, 32'd1);
        chk("t3_no_start", {31'd0, ifa.Tx_Start}, 32'd0);
        ifa.Clear_Overflow = 1'b1;
        @(negedge clk);
        ifa.Clear_Overflow = 1'b0;
        chk("t3_overflow_cleared", {31'd0, ifa.Overflow}, 32'd0);

        // Test 4: push at Full on the pop cycle is accepted
        auto_a = 1'b1; force_a = 1'b0;
        n = 0;
        while (!ifa.Word_Done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("t4_wd_timeout", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
        ifa.WriteEnable = 1'b1; ifa.Data_In = 32'hCAFEF00D; ifa.MSB_First = 1'b1;
        @(negedge clk);
        ifa.WriteEnable = 1'b0; ifa.MSB_First = 1'b0;
        chk("t4_level", {28'd0, ifa.Level}, 32'd8);
        chk("t4_full",  {31'd0, ifa.Full}, 32'd1);
        chk("t4_overflow", {31'd0, ifa.Overflow}, 32'd0);
        wait_a_drained("t4_drain_timeout", 4000);
        chk("t4_nbytes", log_a.size(), 32'd40);
        if (log_a.size() == 40) begin
            chk("t4_first_word", {log_a[3], log_a[2], log_a[1], log_a[0]}, 32'h10000001);
            chk("t4_last_word",  {log_a[36], log_a[37], log_a[38], log_a[39]}, 32'hCAFEF00D);
        end

        // Test 5: asynchronous reset mid-word
        log_a.delete();
        ifa.WriteEnable = 1'b1; ifa.Data_In = 32'h55667788; ifa.MSB_First = 1'b1;
        @(negedge clk);
        ifa.WriteEnable = 1'b0; ifa.MSB_First = 1'b0;
        n = 0;
        while (log_a.size() < 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_two_bytes_timeout", (n < 500) ? 32'd1 : 32'd0, 32'd1);
        #2 rst_a = 1'b0;
        #1;
        chk("t5_rst_tx_start", {31'd0, ifa.Tx_Start}, 32'd0);
        chk("t5_rst_tx_data",  {24'd0, ifa.Tx_Data}, 32'd0);
        chk("t5_rst_empty",    {31'd0, ifa.Empty}, 32'd1);
        chk("t5_rst_level",    {28'd0, ifa.Level}, 32'd0);
        chk("t5_rst_busy",     {31'd0, ifa.Busy}, 32'd0);
        @(negedge clk);
        rst_a = 1'b1;
        repeat (100) @(negedge clk);
        chk("t5_no_more_bytes", log_a.size(), 32'd2);
        if (log_a.size() == 2) begin
            chk("t5_bytes", {16'd0, log_a[0], log_a[1]}, 32'h5566);
        end

        // Test 6: 2-byte / 4-deep instance
        ifb.WriteEnable = 1'b1; ifb.Data_In = 16'hBEEF; ifb.MSB_First = 1'b1;
        @(negedge clk);
        ifb.WriteEnable = 1'b0; ifb.MSB_First = 1'b0;
        wait_b_drained("t6_drain_timeout", 500);
        chk("t6_nbytes", log_b.size(), 32'd2);
        if (log_b.size() == 2) begin
            chk("t6_bytes", {16'd0, log_b[0], log_b[1]}, 32'hBEEF);
        end
        chk("t6_word_done", wd_b, 32'd1);
        auto_b = 1'b0; force_b = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ifb.WriteEnable = 1'b1; ifb.Data_In = 16'h0100 + 16'(i);
            @(negedge clk);
        end
        ifb.WriteEnable = 1'b0;
        chk("t6_full_5",     {31'd0, ifb.Full}, 32'd1);
        chk("t6_level_5",    {29'd0, ifb.Level}, 32'd4);
        chk("t6_no_overflow",{31'd0, ifb.Overflow}, 32'd0);
        ifb.WriteEnable = 1'b1; ifb.Data_In = 16'h0106;
        @(negedge clk);
        ifb.WriteEnable = 1'b0;
        chk("t6_overflow_6", {31'd0, ifb.Overflow}, 32'd1);
        chk("t6_level_6",    {29'd0, ifb.Level}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/uart_word_serializer.md
Name: uart_word_serializer

Overview:
- Parametrised word-to-byte serializer between a word-producing datapath and a UART transmitter.
- Buffers WORD_BYTES-wide words in an internal FIFO and sends each one byte by byte over a Tx_Start/Tx_Busy handshake.
- Byte order is selectable per word; reports buffer level, overflow and per-word completion.

Parameters:
- WORD_BYTES, 4, bytes per word (>=1); Data_In width = 8*WORD_BYTES
- FIFO_DEPTH, 8, word entries in the internal FIFO (power of two, >=2)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- WriteEnable  in  1  push Data_In into the FIFO this cycle
- Data_In  in  8*WORD_BYTES  word to transmit
- MSB_First  in  1  byte order, captured with each word at push time
- Clear_Overflow  in  1  clears the Overflow flag
- Tx_Busy  in  1  UART transmitter busy
- Tx_Start  out  1  byte-valid request to the UART
- Tx_Data  out  8  byte to the UART
- Full  out  1  FIFO full
- Empty  out  1  FIFO empty
- Level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy, 0..FIFO_DEPTH
- Overflow  out  1  sticky flag: a push was dropped
- Busy  out  1  a word is in flight (state != IDLE)
- Word_Done  out  1  one-cycle pulse when the last byte of a word completes

Behaviour:
- Reset (Reset=0, asynchronous):
  - All outputs go to 0, except Empty=1.
  - FIFO is flushed, FSM goes to IDLE, and the shift register and byte counter clear.
  - Reset mid-word abandons the word; no further Tx_Start is issued for it.
- FIFO:
  - Each entry stores {MSB_First, Data_In}.
  - A push is accepted when WriteEnable=1 and either (not Full) or a pop occurs in the same cycle.
  - A push at Full with no simultaneous pop is dropped and sets Overflow=1 on that edge.
  - Overflow holds until Clear_Overflow=1. If a clear and a new drop coincide, Overflow stays 1.
  - Full, Empty and Level are registered and update on the edge of the push/pop.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SEND, ACK, WAIT. Byte counter cnt runs 0..WORD_BYTES-1.
  - IDLE: if not Empty, pop the head into the shift register, latch its order bit, set cnt=0, go to SEND. Tx_Busy is ignored in this state.
  - SEND: if Tx_Busy=0, drive Tx_Data with byte index cnt (MSB order: byte WORD_BYTES-1-cnt; LSB order: byte cnt), set Tx_Start=1, go to ACK. Otherwise stay in SEND.
  - ACK: hold Tx_Start=1 and Tx_Data stable until Tx_Busy is sampled 1. Then set Tx_Start=0 and go to WAIT.
  - WAIT: when Tx_Busy=0:
    - If cnt==WORD_BYTES-1, pulse Word_Done and go to IDLE.
    - Otherwise increment cnt and go to SEND.
- Latency:
  - With an empty FIFO and an idle UART, a push at edge k makes Empty=0 after edge k, pops at edge k+1, and Tx_Start=1 after edge k+2.
  - Back-to-back words: IDLE costs exactly one cycle between Word_Done and the next pop.
- Data stability: Tx_Data changes only on the SEND->ACK edge.
- Inputs during transmission: MSB_First changes mid-word have no effect; order applies per word at push time.
- Tx_Busy never rising while Tx_Start=1 leaves the block in ACK indefinitely; this is legal and there is no timeout.
- WORD_BYTES=1: each word is a single byte and Word_Done follows every byte.

Test Plan:
- Push 0xA1B2C3D4 with MSB_First=1; UART model asserts Tx_Busy 1 cycle after Tx_Start for 10 cycles -> Tx_Data sequence A1,B2,C3,D4. Four Tx_Start assertions, one Word_Done, Busy returns to 0.
- Push 0xA1B2C3D4 (MSB_First=0) then 0x11223344 (MSB_First=1) back-to-back -> D4,C3,B2,A1,11,22,33,44. Word_Done twice, Level peaks at 1.
- Hold Tx_Busy=1 and push 10 words -> word 1 is popped (FSM in SEND), words 2..9 fill the FIFO (Full=1, Level=8), word 10 is dropped and Overflow=1. Pulse Clear_Overflow -> Overflow=0.
- With the FIFO full, issue WriteEnable on the same cycle IDLE pops -> push accepted, Level stays 8, Overflow stays 0.
- Assert Reset=0 asynchronously mid-word, after 2 bytes are sent -> Tx_Start=0, Tx_Data=0, Empty=1, Level=0, Busy=0 immediately. After release, no further bytes from that word appear.
- Instance with WORD_BYTES=2, FIFO_DEPTH=4: push 0xBEEF MSB-first -> BE,EF. Five pushes with Tx_Busy held high -> Full after the fifth and no overflow; a sixth push sets Overflow.
